// File: rtl/i2c_sample_target.sv
// I2C target: answers ADDR, accepts written bytes and streams 16-bit samples
// MSB-first on reads. It never stretches the clock and oversamples SCL/SDA with clk.
module i2c_sample_target #(
  parameter logic [6:0]  ADDR        = 7'h48,
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] IDLE_SAMPLE = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  input  logic [15:0] sample_data,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        busy
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ADDR    = 3'd1;
  localparam logic [2:0] S_ADDR_ACK= 3'd2;
  localparam logic [2:0] S_WR_BYTE = 3'd3;
  localparam logic [2:0] S_WR_ACK  = 3'd4;
  localparam logic [2:0] S_RD_BYTE = 3'd5;
  localparam logic [2:0] S_RD_ACK  = 3'd6;
  localparam logic [2:0] S_WAIT_STOP = 3'd7;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic scl_prev_q, sda_prev_q;
  logic scl_s, sda_s, scl_rise, scl_fall, sda_rise, sda_fall, start_c, stop_c;

  logic [2:0]  state_q, state_d;
  logic [3:0]  bcnt_q, bcnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [15:0] tx_q, tx_d;
  logic        oe_q, oe_d, busy_q, busy_d, rw_q, rw_d, half_q, half_d;
  logic [7:0]  rxd_q, rxd_d;
  logic        rxv_q, rxv_d, srdy_q, srdy_d;

  assign scl_s    = scl_sync_q[SYNC_STAGES-1];
  assign sda_s    = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_prev_q;
  assign scl_fall = ~scl_s & scl_prev_q;
  assign sda_rise = sda_s & ~sda_prev_q;
  assign sda_fall = ~sda_s & sda_prev_q;
  assign start_c  = sda_fall & scl_s;
  assign stop_c   = sda_rise & scl_s;

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    rw_d    = rw_q;
    half_d  = half_q;
    rxd_d   = rxd_q;
    rxv_d   = 1'b0;
    srdy_d  = 1'b0;
    if (start_c) begin
      state_d = S_ADDR;
      bcnt_d  = 4'd0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (stop_c) begin
      state_d = S_IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_ADDR, S_WR_BYTE: begin
          if (scl_rise) begin
            shreg_d = {shreg_q[6:0], sda_s};
            bcnt_d  = bcnt_q + 4'd1;
          end else if (scl_fall && bcnt_q == 4'd8) begin
            bcnt_d = 4'd0;
            if (state_q == S_WR_BYTE) begin
              rxd_d   = shreg_q;
              rxv_d   = 1'b1;
              oe_d    = 1'b1;
              state_d = S_WR_ACK;
            end else if (shreg_q[7:1] == ADDR) begin
              oe_d    = 1'b1;
              busy_d  = 1'b1;
              rw_d    = shreg_q[0];
              state_d = S_ADDR_ACK;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_ADDR_ACK: begin
          // Fetch while the target holds ACK so the MSB is ready at the ACK fall.
          if (scl_rise && rw_q) begin
            tx_d   = sample_valid ? sample_data : IDLE_SAMPLE;
            srdy_d = sample_valid;
          end else if (scl_fall) begin
            bcnt_d = 4'd0;
            half_d = 1'b0;
            if (rw_q) begin
              oe_d    = ~tx_q[15];
              state_d = S_RD_BYTE;
            end else begin
              oe_d    = 1'b0;
              state_d = S_WR_BYTE;
            end
          end
        end
        S_WR_ACK: begin
          if (scl_fall) begin
            oe_d    = 1'b0;
            state_d = S_WR_BYTE;
          end
        end
        S_RD_BYTE: begin
          if (scl_fall) begin
            tx_d = {tx_q[14:0], 1'b0};
            if (bcnt_q == 4'd7) begin
              bcnt_d  = 4'd0;
              oe_d    = 1'b0;
              state_d = S_RD_ACK;
            end else begin
              bcnt_d = bcnt_q + 4'd1;
              oe_d   = ~tx_q[14];
            end
          end
        end
        S_RD_ACK: begin
          if (scl_rise) begin
            if (sda_s) state_d = S_WAIT_STOP;
            else if (half_q) begin
              tx_d   = sample_valid ? sample_data : IDLE_SAMPLE;
              srdy_d = sample_valid;
            end
          end else if (scl_fall) begin
            half_d  = ~half_q;
            oe_d    = ~tx_q[15];
            state_d = S_RD_BYTE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= S_IDLE;
      bcnt_q     <= 4'd0;
      shreg_q    <= 8'd0;
      tx_q       <= IDLE_SAMPLE;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
      half_q     <= 1'b0;
      rxd_q      <= 8'd0;
      rxv_q      <= 1'b0;
      srdy_q     <= 1'b0;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
      state_q    <= state_d;
      bcnt_q     <= bcnt_d;
      shreg_q    <= shreg_d;
      tx_q       <= tx_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      rw_q       <= rw_d;
      half_q     <= half_d;
      rxd_q      <= rxd_d;
      rxv_q      <= rxv_d;
      srdy_q     <= srdy_d;
    end
  end

  assign sda_oe       = oe_q;
  assign busy         = busy_q;
  assign rx_data      = rxd_q;
  assign rx_valid     = rxv_q;
  assign sample_ready = srdy_q;
endmodule

// File: tb/tb_i2c_sample_target.sv
// Directed bench for i2c_sample_target: a bit-banged master on a wired-AND SDA.
module tb_i2c_sample_target;
  localparam int Q = 10;  // clk cycles per quarter SCL period

  logic        clk = 1'b0, rst = 1'b0;
  logic        scl_m = 1'b1, sda_m = 1'b1;
  logic        sda_oe, sample_ready, rx_valid, busy;
  logic [15:0] sample_data = 16'h0000, nxt = 16'h0000;
  logic        sample_valid = 1'b0;
  logic [7:0]  rx_data;
  logic        sda_bus;
  int          errs = 0, checks = 0;
  int          n_rx = 0, n_rdy = 0, n_both = 0;
  logic [7:0]  rx_log [0:7];
  logic        ack;
  logic [7:0]  b;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_sample_target dut (
    .clk(clk), .rst(rst), .scl_i(scl_m), .sda_i(sda_bus), .sda_oe(sda_oe),
    .sample_data(sample_data), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) begin
      if (n_rx < 8) rx_log[n_rx] = rx_data;
      n_rx++;
    end
    if (sample_ready) begin
      n_rdy++;
      sample_data = nxt;
    end
    if (rx_valid && sample_ready) n_both++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic qw(); repeat (Q) @(posedge clk); endtask

  task automatic i2c_start();
    sda_m = 1'b1; qw(); scl_m = 1'b1; qw(); sda_m = 1'b0; qw(); scl_m = 1'b0; qw();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; qw(); scl_m = 1'b1; qw(); sda_m = 1'b1; qw(); qw();
  endtask

  task automatic wbit(input logic v);
    sda_m = v; qw(); scl_m = 1'b1; qw(); qw(); scl_m = 1'b0; qw();
  endtask

  task automatic rbit(output logic v);
    sda_m = 1'b1; qw(); scl_m = 1'b1; qw(); v = sda_bus; qw(); scl_m = 1'b0; qw();
  endtask

  task automatic wbyte(input logic [7:0] d, output logic a);
    for (int i = 7; i >= 0; i--) wbit(d[i]);
    rbit(a);
  endtask

  task automatic rbyte(input logic nack, output logic [7:0] d);
    logic v;
    for (int i = 7; i >= 0; i--) begin
      rbit(v);
      d[i] = v;
    end
    wbit(nack);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_sample_ready", sample_ready, 0);
    rst = 1'b1;
    repeat (5) @(posedge clk);

    // Write 0xA5, 0x3C
    i2c_start();
    wbyte(8'h90, ack); chk("wr_addr_ack", ack, 0);
    chk("wr_busy", busy, 1);
    wbyte(8'hA5, ack); chk("wr_d0_ack", ack, 0);
    wbyte(8'h3C, ack); chk("wr_d1_ack", ack, 0);
    i2c_stop(); qw();
    chk("wr_rx_count", n_rx, 2);
    chk("wr_rx0", rx_log[0], 8'hA5);
    chk("wr_rx1", rx_log[1], 8'h3C);
    chk("wr_rx_data", rx_data, 8'h3C);
    chk("wr_busy_stop", busy, 0);

    // Read two samples
    sample_data = 16'h1234; nxt = 16'hBEEF; sample_valid = 1'b1;
    i2c_start();
    wbyte(8'h91, ack); chk("rd_addr_ack", ack, 0);
    rbyte(1'b0, b); chk("rd_b0", b, 8'h12);
    rbyte(1'b0, b); chk("rd_b1", b, 8'h34);
    rbyte(1'b0, b); chk("rd_b2", b, 8'hBE);
    rbyte(1'b1, b); chk("rd_b3", b, 8'hEF);
    i2c_stop(); qw();
    chk("rd_ready_count", n_rdy, 2);
    chk("rd_busy_stop", busy, 0);
    sample_valid = 1'b0;

    // Wrong address
    i2c_start();
    wbyte(8'h92, ack); chk("na_addr_nack", ack, 1);
    chk("na_busy", busy, 0);
    wbyte(8'h00, ack); chk("na_data_nack", ack, 1);
    i2c_stop(); qw();
    chk("na_rx_count", n_rx, 2);

    // Read with no valid sample
    i2c_start();
    wbyte(8'h91, ack); chk("idle_addr_ack", ack, 0);
    rbyte(1'b0, b); chk("idle_b0", b, 8'h00);
    rbyte(1'b1, b); chk("idle_b1", b, 8'h00);
    i2c_stop(); qw();
    chk("idle_ready_count", n_rdy, 2);

    // Partial write aborted by repeated START, then read
    i2c_start();
    wbyte(8'h90, ack); chk("rs_addr_ack", ack, 0);
    for (int i = 0; i < 4; i++) wbit(1'b1);
    sample_data = 16'hCAFE; nxt = 16'hCAFE; sample_valid = 1'b1;
    i2c_start();
    wbyte(8'h91, ack); chk("rs_raddr_ack", ack, 0);
    rbyte(1'b0, b); chk("rs_b0", b, 8'hCA);
    rbyte(1'b1, b); chk("rs_b1", b, 8'hFE);
    i2c_stop(); qw();
    chk("rs_rx_count", n_rx, 2);
    chk("rs_ready_count", n_rdy, 3);
    sample_valid = 1'b0;

    // Reset mid-read while driving a 0 bit
    i2c_start();
    wbyte(8'h91, ack); chk("rr_addr_ack", ack, 0);
    qw();
    chk("rr_sda_driven", sda_oe, 1);
    @(negedge clk); #2;
    rst = 1'b0; #1;
    chk("rr_sda_async", sda_oe, 0);
    chk("rr_busy", busy, 0);
    repeat (3) @(posedge clk);
    rst = 1'b1;
    i2c_stop(); qw();
    i2c_start();
    wbyte(8'h90, ack); chk("rr_wr_ack", ack, 0);
    wbyte(8'h55, ack); chk("rr_d_ack", ack, 0);
    i2c_stop(); qw();
    chk("rr_rx_data", rx_data, 8'h55);
    chk("rr_rx_count", n_rx, 3);
    chk("excl_pulses", n_both, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
